// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, centre-sampling bit timer and
// valid/ready byte output with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync1_q;
    logic          rxd_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          expire;

    // A phase of length L is loaded as L and ends on the cycle the counter reads 1.
    assign expire = (cnt_q == CW'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_CNT;
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rxd_s_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        cnt_d   = FULL_CNT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shreg_d[idx_q] = rxd_s_q;
                    cnt_d          = FULL_CNT;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (expire) begin
                    if (rxd_s_q) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q && !rx_ready;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxd_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random byte streams
// compared against a byte-level reference queue.
module tb_uart_rx;

    localparam int unsigned CPB = 87;

    logic       clk;
    logic       resetn;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned checks = 0;
    int unsigned passes = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: cumulative event counts, sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned fe_cnt = 0;
    int unsigned ov_cnt = 0;
    int unsigned hs_cnt = 0;
    int unsigned rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        if (rx_valid && rx_ready) begin
            hs_cnt <= hs_cnt + 1;
            got_q.push_back(rx_data);
        end
        prev_valid <= rx_valid;
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a full frame starting right after a rising edge; line is left at
    // the stop-bit level so callers decide what follows.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              output int unsigned start_cyc);
        rxd = 1'b0;
        start_cyc = cyc;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(CPB);
        end
        rxd = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b0;
        wait_cycles(5);
        resetn = 1'b1;
        wait_cycles(2000);
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (frame_err !== 1'b0 || fe_cnt != 0) $display("FAIL reset_frame_err got=%b cnt=%0d exp=0", frame_err, fe_cnt); else passes++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else passes++;
    endtask

    task automatic test_single;
        int unsigned st, hs0, lat;
        rx_ready = 1'b1;
        hs0 = hs_cnt;
        send_frame(8'hA5, 1'b1, st);
        rxd = 1'b1;
        wait_cycles(20);
        lat = rise_cyc - st;
        checks++; if (lat < 829 || lat > 831) $display("FAIL single_latency got=%0d exp=830+-1", lat); else passes++;
        checks++; if (hs_cnt - hs0 != 1) $display("FAIL single_handshakes got=%0d exp=1", hs_cnt - hs0); else passes++;
        checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'hA5) $display("FAIL single_byte got=%h exp=a5", rx_data); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL single_valid_drop got=%b exp=0", rx_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        int unsigned st, ov0, hs0;
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        hs0 = hs_cnt;
        send_frame(8'h3C, 1'b1, st);
        send_frame(8'hC3, 1'b1, st);
        rxd = 1'b1;
        wait_cycles(20);
        checks++; if (rx_data !== 8'hC3) $display("FAIL b2b_data got=%h exp=c3", rx_data); else passes++;
        checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", rx_valid); else passes++;
        checks++; if (ov_cnt - ov0 != 1) $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - ov0); else passes++;
        checks++; if (hs_cnt != hs0) $display("FAIL b2b_no_handshake got=%0d exp=0", hs_cnt - hs0); else passes++;
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(2);
        checks++; if (rx_valid !== 1'b0) $display("FAIL b2b_consume got=%b exp=0", rx_valid); else passes++;
        checks++; if (rx_data !== 8'hC3) $display("FAIL b2b_hold got=%h exp=c3", rx_data); else passes++;
        rx_ready = 1'b1;
    endtask

    task automatic test_framing;
        int unsigned st, fe0, hs0;
        fe0 = fe_cnt;
        hs0 = hs_cnt;
        send_frame(8'h55, 1'b0, st);
        wait_cycles(3 * CPB);
        checks++; if (fe_cnt - fe0 != 1) $display("FAIL frame_err_count got=%0d exp=1", fe_cnt - fe0); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL frame_busy_low got=%b exp=1", busy); else passes++;
        checks++; if (rx_valid !== 1'b0 || hs_cnt != hs0) $display("FAIL frame_no_valid got=%b exp=0", rx_valid); else passes++;
        rxd = 1'b1;
        wait_cycles(10);
        checks++; if (busy !== 1'b0) $display("FAIL frame_recover got=%b exp=0", busy); else passes++;
        checks++; if (fe_cnt - fe0 != 1) $display("FAIL frame_err_single got=%0d exp=1", fe_cnt - fe0); else passes++;
    endtask

    task automatic test_glitch;
        int unsigned st, fe0, hs0;
        fe0 = fe_cnt;
        hs0 = hs_cnt;
        rxd = 1'b0;
        wait_cycles(20);
        rxd = 1'b1;
        wait_cycles(100);
        checks++; if (busy !== 1'b0) $display("FAIL glitch_idle got=%b exp=0", busy); else passes++;
        checks++; if (hs_cnt != hs0 || fe_cnt != fe0) $display("FAIL glitch_no_output hs=%0d fe=%0d exp=0", hs_cnt - hs0, fe_cnt - fe0); else passes++;
        send_frame(8'h01, 1'b1, st);
        rxd = 1'b1;
        wait_cycles(20);
        checks++; if (hs_cnt - hs0 != 1 || got_q[got_q.size()-1] !== 8'h01) $display("FAIL glitch_next_byte got=%h exp=01", rx_data); else passes++;
    endtask

    task automatic test_reset_mid;
        int unsigned st, hs0, fe0;
        rxd = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            wait_cycles(CPB);
        end
        wait_cycles(40);
        resetn = 1'b0;
        wait_cycles(3);
        resetn = 1'b1;
        hs0 = hs_cnt;
        fe0 = fe_cnt;
        wait_cycles(6 * CPB);
        checks++; if (hs_cnt != hs0 || fe_cnt != fe0 || rx_valid !== 1'b0) $display("FAIL midreset_no_output hs=%0d fe=%0d valid=%b exp=0", hs_cnt - hs0, fe_cnt - fe0, rx_valid); else passes++;
        checks++; if (rx_data !== 8'h00) $display("FAIL midreset_data got=%h exp=00", rx_data); else passes++;
        send_frame(8'h0F, 1'b1, st);
        rxd = 1'b1;
        wait_cycles(20);
        checks++; if (rx_data !== 8'h0F || hs_cnt - hs0 != 1) $display("FAIL midreset_next got=%h exp=0f", rx_data); else passes++;
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int unsigned st, base, fe0, ov0, bad;
        base = got_q.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, st);
            rxd = 1'b1;
            wait_cycles($urandom_range(0, 200));
        end
        wait_cycles(20);
        checks++; if (got_q.size() - base != exp_q.size()) $display("FAIL random_count got=%0d exp=%0d", got_q.size() - base, exp_q.size()); else passes++;
        bad = 0;
        for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
            if (got_q[base + k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL random_byte idx=%0d got=%h exp=%h", k, got_q[base + k], exp_q[k]);
                bad++;
            end
        end
        checks++; if (bad != 0) $display("FAIL random_bytes mismatched=%0d exp=0", bad); else passes++;
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL random_flags fe=%0d ov=%0d exp=0", fe_cnt - fe0, ov_cnt - ov0); else passes++;
    endtask

    initial begin
        resetn = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_framing;
        test_glitch;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
